// File: rtl/bsg_fpu_normalize_pipe_pkg.sv
// Shared FPU constants and the stage payload carried from S1 into S2.
// Payload fields are sized for the widest supported operand and narrowed at the block boundary.
package bsg_fpu_normalize_pipe_pkg;

    localparam int fpu_width_gp         = 32;
    localparam int fpu_exp_width_gp     = 8;
    localparam int fpu_max_width_gp     = 64;
    localparam int fpu_max_exp_width_gp = 16;
    localparam int fpu_max_lz_width_gp  = $clog2(fpu_max_width_gp);

    typedef struct packed {
        logic                            sign;
        logic [fpu_max_exp_width_gp-1:0] exp;
        logic [fpu_max_width_gp-1:0]     mant;
        logic [fpu_max_lz_width_gp-1:0]  lz;
        logic                            zero;
    } fpu_payload_s;

endpackage

// File: rtl/bsg_fpu_normalize_pipe_if.sv
// Operand/result handshake bundle of the normalize pipe.
// The slave modport is the pipe itself; the master modport is its client.
interface bsg_fpu_normalize_pipe_if
    import bsg_fpu_normalize_pipe_pkg::*;
#(
    parameter int width_p     = fpu_width_gp,
    parameter int exp_width_p = fpu_exp_width_gp
) ();

    logic                   v_i;
    logic                   ready_o;
    logic                   sign_i;
    logic [exp_width_p-1:0] exp_i;
    logic [width_p-1:0]     mant_i;

    logic                   v_o;
    logic                   yumi_i;
    logic                   sign_o;
    logic [exp_width_p-1:0] exp_o;
    logic [width_p-1:0]     mant_o;
    logic                   zero_o;
    logic                   denorm_o;

    modport slave (
        input  v_i, sign_i, exp_i, mant_i, yumi_i,
        output ready_o, v_o, sign_o, exp_o, mant_o, zero_o, denorm_o
    );

    modport master (
        output v_i, sign_i, exp_i, mant_i, yumi_i,
        input  ready_o, v_o, sign_o, exp_o, mant_o, zero_o, denorm_o
    );

endinterface

// File: rtl/bsg_fpu_normalize_pipe_clz.sv
// Leading-zero counter; an all-zero input reports all ones, which callers
// must override with their own zero detection.
module bsg_fpu_clz #(
    parameter int width_p          = 32,
    parameter int num_zero_width_p = $clog2(width_p)
) (
    input  logic [width_p-1:0]          a_i,
    output logic [num_zero_width_p-1:0] num_zero_o
);

    // Scanning upward lets the highest set bit win the final assignment.
    always_comb begin
        num_zero_o = '1;
        for (int i = 0; i < width_p; i++) begin
            if (a_i[i]) begin
                num_zero_o = num_zero_width_p'(width_p - 1 - i);
            end
        end
    end

endmodule

// File: rtl/bsg_fpu_normalize_pipe.sv
// Two-stage mantissa normalizer: S1 captures the operand with its leading-zero count,
// S2 captures the left-shifted mantissa, adjusted exponent and zero/subnormal flags.
module bsg_fpu_normalize_pipe
    import bsg_fpu_normalize_pipe_pkg::*;
#(
    parameter int width_p     = fpu_width_gp,
    parameter int exp_width_p = fpu_exp_width_gp
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bsg_fpu_normalize_pipe_if.slave  io
);

    localparam int lz_width_lp = $clog2(width_p);

    logic                  s1_v_r;
    logic                  s2_v_r;
    logic                  s1_advance;
    logic                  accept;
    logic [lz_width_lp-1:0] lz_raw;

    fpu_payload_s s1_n;
    fpu_payload_s s1_r;

    logic                            lz_lt_exp;
    logic [fpu_max_lz_width_gp-1:0]  shift_amt;
    logic [fpu_max_width_gp-1:0]     mant_shifted;
    logic [fpu_max_exp_width_gp-1:0] exp_adj;
    logic                            denorm_n;

    logic                   s2_sign_r;
    logic [exp_width_p-1:0] s2_exp_r;
    logic [width_p-1:0]     s2_mant_r;
    logic                   s2_zero_r;
    logic                   s2_denorm_r;

    assign s1_advance = s1_v_r & (~s2_v_r | io.yumi_i);
    assign io.ready_o = ~s1_v_r | s1_advance;
    assign accept     = io.v_i & io.ready_o;

    bsg_fpu_clz #(
        .width_p          (width_p),
        .num_zero_width_p (lz_width_lp)
    ) clz (
        .a_i        (io.mant_i),
        .num_zero_o (lz_raw)
    );

    always_comb begin
        s1_n      = '0;
        s1_n.sign = io.sign_i;
        s1_n.exp  = fpu_max_exp_width_gp'(io.exp_i);
        s1_n.mant = fpu_max_width_gp'(io.mant_i);
        s1_n.lz   = fpu_max_lz_width_gp'(lz_raw);
        s1_n.zero = (io.mant_i == '0);
    end

    // When the exponent caps the shift it is no larger than lz, so it fits the shift
    // amount and the subtraction below can never wrap.
    always_comb begin
        lz_lt_exp    = fpu_max_exp_width_gp'(s1_r.lz) < s1_r.exp;
        shift_amt    = lz_lt_exp ? s1_r.lz : fpu_max_lz_width_gp'(s1_r.exp);
        mant_shifted = s1_r.mant << shift_amt;
        exp_adj      = '0;
        denorm_n     = 1'b0;
        if (!s1_r.zero) begin
            if (lz_lt_exp) begin
                exp_adj = s1_r.exp - fpu_max_exp_width_gp'(s1_r.lz);
            end else begin
                denorm_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v_r <= 1'b0;
            s2_v_r <= 1'b0;
        end else begin
            if (accept) begin
                s1_v_r <= 1'b1;
            end else if (s1_advance) begin
                s1_v_r <= 1'b0;
            end

            if (s1_advance) begin
                s2_v_r <= 1'b1;
            end else if (io.yumi_i) begin
                s2_v_r <= 1'b0;
            end
        end
    end

    // Payload registers are qualified by the valid bits, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            s1_r <= s1_n;
        end
        if (s1_advance) begin
            s2_sign_r   <= s1_r.sign;
            s2_exp_r    <= exp_width_p'(exp_adj);
            s2_mant_r   <= width_p'(mant_shifted);
            s2_zero_r   <= s1_r.zero;
            s2_denorm_r <= denorm_n;
        end
    end

    assign io.v_o      = s2_v_r;
    assign io.sign_o   = s2_sign_r;
    assign io.exp_o    = s2_exp_r;
    assign io.mant_o   = s2_mant_r;
    assign io.zero_o   = s2_zero_r;
    assign io.denorm_o = s2_denorm_r;

endmodule

// File: doc/bsg_fpu_normalize_pipe.md
BSG_FPU_NORMALIZE_PIPE -- requirements
Module: bsg_fpu_normalize_pipe

Interface
REQ-001 The block SHALL have parameter width_p, default 32, giving the mantissa width (power of two, 8..64).
REQ-002 The block SHALL have parameter exp_width_p, default 8, giving the unsigned biased exponent width.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port v_i, input, 1 bit: the input operand is valid.
REQ-006 The block SHALL have port ready_o, output, 1 bit: the block can accept an operand this cycle.
REQ-007 The block SHALL have port sign_i, input, 1 bit: the operand sign, passed through unchanged.
REQ-008 The block SHALL have port exp_i, input, exp_width_p bits: the unnormalized biased exponent.
REQ-009 The block SHALL have port mant_i, input, width_p bits: the unnormalized mantissa, with MSB as the hidden-bit position.
REQ-010 The block SHALL have port v_o, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port yumi_i, input, 1 bit: downstream consumes the result; it is legal only when v_o=1.
REQ-012 The block SHALL have port sign_o, output, 1 bit: the registered sign.
REQ-013 The block SHALL have port exp_o, output, exp_width_p bits: the adjusted exponent.
REQ-014 The block SHALL have port mant_o, output, width_p bits: the left-normalized mantissa.
REQ-015 The block SHALL have port zero_o, output, 1 bit: the input mantissa was all zeros.
REQ-016 The block SHALL have port denorm_o, output, 1 bit: the shift was limited by the exponent, so the result is subnormal.

Function
REQ-017 The block SHALL be a 2-stage pipeline: S1 registers the operand and its leading-zero count lz; S2 registers the shifted result.
REQ-018 A handshake SHALL occur when v_i & ready_o is true; ready_o SHALL equal ~S1.valid | S1 advancing.
REQ-019 S1 SHALL advance into S2 when S1.valid & (~S2.valid | yumi_i).
REQ-020 S2 SHALL be cleared when yumi_i=1 and nothing advances from S1.
REQ-021 v_o SHALL equal S2.valid, and the S2 outputs SHALL hold stable while v_o=1 & yumi_i=0.
REQ-022 Latency SHALL be 2 cycles from the handshake to v_o with no stall, and throughput SHALL be 1 operand per cycle under continuous yumi_i.
REQ-023 S1 SHALL compute lz as the count of leading zeros of mant_i, with width $clog2(width_p).
REQ-024 If mant_i==0, S2 SHALL produce zero_o=1, mant_o=0, exp_o=0, denorm_o=0, and sign_o passed through.
REQ-025 If mant_i!=0 and lz < exp_i, S2 SHALL produce mant_o=mant<<lz, exp_o=exp_i-lz, denorm_o=0.
REQ-026 If mant_i!=0 and lz >= exp_i, S2 SHALL produce mant_o=mant<<exp_i, exp_o=0, denorm_o=1.
REQ-027 For REQ-026, exp_i=0 SHALL mean no shift.
REQ-028 The exponent arithmetic SHALL be unsigned and SHALL never wrap; the REQ-026 saturation guarantees this.
REQ-029 A new input and a downstream yumi_i in the same cycle with both stages full SHALL move both stages with no bubble and no loss of data.

Reset
REQ-030 reset_n_i=0 SHALL asynchronously clear S1.valid and S2.valid.
REQ-031 During reset, v_o SHALL be 0 and ready_o SHALL be 1 once reset is released.
REQ-032 Data registers SHALL not require reset, and the outputs other than v_o SHALL be don't-care while v_o=0.
REQ-033 A reset asserted mid-operation SHALL discard all in-flight operands, and no output SHALL appear for them.

Structure
REQ-034 A shared FPU package SHALL hold the default width constants and the S1/S2 payload struct: sign, exp, mant, lz, zero.
REQ-035 The block SHALL instantiate one sub-module, bsg_fpu_clz (width_p input, $clog2(width_p) output), in S1.
REQ-036 The left shifter SHALL be inline combinational logic.

Verification
REQ-037 The bench SHALL cover: mant_i=32'h0000_1000, exp_i=8'd100, sign_i=1 -> two cycles later mant_o=32'h8000_0000, exp_o=8'd81, sign_o=1, denorm_o=0, zero_o=0.
REQ-038 The bench SHALL cover: mant_i=32'h0000_0001, exp_i=8'd5 -> mant_o=32'h0000_0020, exp_o=0, denorm_o=1.
REQ-039 The bench SHALL cover: mant_i=0, exp_i=8'd77 -> zero_o=1, exp_o=0, mant_o=0.
REQ-040 The bench SHALL cover: 4 back-to-back operands with yumi_i tied to 1 -> v_o is high for 4 consecutive cycles starting at cycle 2, in order.
REQ-041 The bench SHALL cover: yumi_i=0 with 3 operands offered -> exactly 2 accepted, ready_o=0 on the third, v_o and data held stable.
REQ-042 The bench SHALL cover: after yumi_i rises, the remaining operands drain in order.
REQ-043 The bench SHALL cover: reset_n_i pulsed low for 1 cycle with both stages full -> v_o=0 immediately, and no stale result appears afterward.
